// File: rtl/data_ram_responder.sv
// data_ram_responder: SLS handshake responder over an internal byte-addressable RAM.
// Define DRR_BIG_ENDIAN_EN for big-endian byte lanes (default is little-endian).
module data_ram_responder #(
    parameter int ADDR_W   = 9,
    parameter int WAIT_CYC = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        RW,
    input  logic        SE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] ADDR,
    input  logic [63:0] DATA_IN,
    output logic [63:0] DATA_OUT,
    output logic        MOC,
    output logic        ALIGN_ERR
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_XFER0, S_XFER1, S_DONE, S_HOLD
    } state_t;

`ifdef DRR_BIG_ENDIAN_EN
    localparam bit BIG_END = 1'b1;
`else
    localparam bit BIG_END = 1'b0;
`endif
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

    logic [7:0] mem [2**ADDR_W];

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic                se_q, se_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         data_q, data_d;
    logic [31:0]         lo_q, lo_d;
    logic [63:0]         dout_q, dout_d;
    logic                moc_q, moc_d;
    logic                aerr_q, aerr_d;

    logic [ADDR_W-1:0]   base;
    logic [2:0]          nbytes;
    logic                misalign;
    logic                wr_ok;
    logic [31:0]         wword;
    logic [31:0]         rd_word;
    logic [63:0]         load_val;
    logic [ADDR_W-1:0]   lane_a [4];
    logic [1:0]          lane_sel [4];
    logic [3:0]          lane_en;
    logic [3:0]          wr_en;
    logic                addr_hi_unused;

    assign addr_hi_unused = ^ADDR[31:ADDR_W];

    // Byte k of the access maps to word lane lane_sel[k]; XFER1 targets ADDR+4.
    always_comb begin
        base = (state_q == S_XFER1) ? addr_q + ADDR_W'(4) : addr_q;
        unique case (size_q)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        unique case (size_q)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr_q[0];
            2'b10:   misalign = |addr_q[1:0];
            default: misalign = |addr_q[2:0];
        endcase
        wword = (state_q == S_XFER1) ? data_q[63:32] : data_q[31:0];
        wr_ok = MFA && !rw_q &&
                ((state_q == S_XFER0 && !misalign) || state_q == S_XFER1);
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            lane_a[k]   = base + ADDR_W'(k);
            lane_en[k]  = 3'(k) < nbytes;
            lane_sel[k] = BIG_END ? 2'(nbytes - 3'(k) - 3'd1) : 2'(k);
            wr_en[k]    = wr_ok && lane_en[k];
            if (lane_en[k])
                rd_word[{lane_sel[k], 3'b000} +: 8] = mem[lane_a[k]];
        end
    end

    always_comb begin
        unique case (size_q)
            2'b00: load_val = se_q ? {{56{rd_word[7]}}, rd_word[7:0]}
                                   : {56'd0, rd_word[7:0]};
            2'b01: load_val = se_q ? {{48{rd_word[15]}}, rd_word[15:0]}
                                   : {48'd0, rd_word[15:0]};
            default: load_val = {32'd0, rd_word};
        endcase
    end

    always_ff @(posedge Clk) begin
        for (int k = 0; k < 4; k++)
            if (wr_en[k])
                mem[lane_a[k]] <= wword[{lane_sel[k], 3'b000} +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        se_d    = se_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lo_d    = lo_q;
        dout_d  = dout_q;
        moc_d   = 1'b0;
        aerr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: if (MFA) begin
                rw_d    = RW;
                se_d    = SE;
                size_d  = SIZE;
                addr_d  = ADDR[ADDR_W-1:0];
                data_d  = DATA_IN;
                cnt_d   = '0;
                state_d = (WAIT_CYC == 0) ? S_XFER0 : S_WAIT;
            end
            S_WAIT: begin
                if (!MFA)                   state_d = S_IDLE;
                else if (cnt_q == WAIT_LAST) state_d = S_XFER0;
                else                        cnt_d   = cnt_q + 4'd1;
            end
            S_XFER0: begin
                if (!MFA) begin
                    state_d = S_IDLE;
                end else if (misalign) begin
                    state_d = S_DONE;
                    moc_d   = 1'b1;
                    aerr_d  = 1'b1;
                end else if (size_q == 2'b11) begin
                    lo_d    = rd_word;
                    state_d = S_XFER1;
                end else begin
                    state_d = S_DONE;
                    moc_d   = 1'b1;
                    if (rw_q) dout_d = load_val;
                end
            end
            S_XFER1: begin
                if (!MFA) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    moc_d   = 1'b1;
                    if (rw_q) dout_d = {rd_word, lo_q};
                end
            end
            S_DONE:  state_d = S_HOLD;
            S_HOLD:  if (!MFA) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            lo_q    <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            se_q    <= se_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            aerr_q  <= aerr_d;
        end
    end

    assign DATA_OUT  = dout_q;
    assign MOC       = moc_q;
    assign ALIGN_ERR = aerr_q;
endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized bench for data_ram_responder against a byte-array reference model.
// Directed cases cover reset, latency, extension, doubleword, alignment and abort.
module tb_data_ram_responder;
    localparam int ADDR_W   = 9;
    localparam int WAIT_CYC = 2;
    localparam int DEPTH    = 2**ADDR_W;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MFA;
    logic        RW;
    logic        SE;
    logic [1:0]  SIZE;
    logic [31:0] ADDR;
    logic [63:0] DATA_IN;
    logic [63:0] DATA_OUT;
    logic        MOC;
    logic        ALIGN_ERR;

    logic [7:0]  mem_m [DEPTH];
    logic [63:0] dout_m;
    int          checks   = 0;
    int          failures = 0;

    data_ram_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
        .Clk(Clk), .Reset(Reset), .MFA(MFA), .RW(RW), .SE(SE),
        .SIZE(SIZE), .ADDR(ADDR), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .MOC(MOC), .ALIGN_ERR(ALIGN_ERR)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int wrap(input logic [31:0] a);
        return int'(a % DEPTH);
    endfunction

    function automatic logic [63:0] rd_n(input int a, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) begin
`ifdef DRR_BIG_ENDIAN_EN
            v = (v << 8) | 64'(mem_m[(a + i) % DEPTH]);
`else
            v = v | (64'(mem_m[(a + i) % DEPTH]) << (8 * i));
`endif
        end
        return v;
    endfunction

    task automatic wr_n(input int a, input int n, input logic [63:0] d);
        for (int i = 0; i < n; i++) begin
`ifdef DRR_BIG_ENDIAN_EN
            mem_m[(a + i) % DEPTH] = 8'(d >> (8 * (n - 1 - i)));
`else
            mem_m[(a + i) % DEPTH] = 8'(d >> (8 * i));
`endif
        end
    endtask

    function automatic logic [63:0] load_m(input int a, input logic [1:0] sz,
                                           input logic se);
        logic [63:0] lo, hi, v;
        int n;
        if (sz == 2'b11) begin
            lo = rd_n(a, 4);
            hi = rd_n(a + 4, 4);
            return (hi << 32) | lo;
        end
        n = 1 << sz;
        v = rd_n(a, n);
        if (se && n < 4 && v[8 * n - 1])
            v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    // One full handshake; hold_extra keeps MFA high after MOC to probe HOLD.
    task automatic req(input logic rw, input logic se, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [63:0] d,
                       input int hold_extra);
        int  a       = wrap(addr);
        bit  mis     = (addr % (32'd1 << sz)) != 0;
        int  exp_lat = (!mis && sz == 2'b11) ? WAIT_CYC + 2 : WAIT_CYC + 1;
        int  got     = -1;
        bit  extra   = 1'b0;
        MFA = 1'b1; RW = rw; SE = se; SIZE = sz; ADDR = addr; DATA_IN = d;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (MOC) begin
                got = k;
                break;
            end
            if (k == 0) begin
                RW = ~rw; SIZE = 2'($urandom); ADDR = $urandom;
                DATA_IN = {$urandom, $urandom}; SE = ~se;
            end
        end
        if (got < 0) begin
            check("moc_timeout", 64'd0, 64'd1);
        end else begin
            check("latency", 64'(got), 64'(exp_lat));
            check("align_err", 64'(ALIGN_ERR), 64'(mis));
            if (!mis) begin
                if (rw) dout_m = load_m(a, sz, se);
                else if (sz == 2'b11) begin
                    wr_n(a, 4, d & 64'hFFFF_FFFF);
                    wr_n(a + 4, 4, d >> 32);
                end else wr_n(a, 1 << sz, d);
            end
            check("data_out", DATA_OUT, dout_m);
        end
        @(posedge Clk);
        @(negedge Clk);
        check("moc_pulse", 64'(MOC), 64'd0);
        for (int k = 0; k < hold_extra; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (MOC) extra = 1'b1;
        end
        if (hold_extra > 0) check("hold_no_moc", 64'(extra), 64'd0);
        MFA = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        bit          seen;
        Reset = 1'b1; MFA = 1'b0; RW = 1'b0; SE = 1'b0; SIZE = '0;
        ADDR = '0; DATA_IN = '0; dout_m = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_dout", DATA_OUT, 64'd0);
        check("rst_moc", 64'(MOC), 64'd0);
        check("rst_aerr", 64'(ALIGN_ERR), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < DEPTH; i += 8)
            req(1'b0, 1'b0, 2'b11, 32'(i), {$urandom, $urandom}, 0);

        // Reset during WAIT of a store: no MOC, target bytes keep old value.
        MFA = 1'b1; RW = 1'b0; SIZE = 2'b10; ADDR = 32'h40;
        DATA_IN = 64'h1234_5678;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        MFA = 1'b0; Reset = 1'b0;
        dout_m = '0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (MOC) seen = 1'b1;
        end
        check("rst_mid_no_moc", 64'(seen), 64'd0);
        check("rst_mid_dout", DATA_OUT, 64'd0);
        req(1'b1, 1'b0, 2'b10, 32'h40, 64'd0, 0);

        req(1'b0, 1'b0, 2'b10, 32'h10, 64'hDEAD_BEEF, 0);
        req(1'b1, 1'b0, 2'b10, 32'h10, 64'd0, 0);
        check("t2_word", DATA_OUT, 64'h0000_0000_DEAD_BEEF);
`ifdef DRR_BIG_ENDIAN_EN
        req(1'b1, 1'b1, 2'b00, 32'h10, 64'd0, 0);
        check("t6_be_byte", DATA_OUT, 64'hFFFF_FFFF_FFFF_FFDE);
`else
        req(1'b1, 1'b1, 2'b00, 32'h13, 64'd0, 0);
        check("t3_byte_se", DATA_OUT, 64'hFFFF_FFFF_FFFF_FFDE);
        req(1'b1, 1'b0, 2'b00, 32'h13, 64'd0, 0);
        check("t3_byte_ze", DATA_OUT, 64'h0000_0000_0000_00DE);
        req(1'b1, 1'b1, 2'b01, 32'h12, 64'd0, 0);
        check("t3_half_se", DATA_OUT, 64'hFFFF_FFFF_FFFF_DEAD);
`endif
        req(1'b0, 1'b0, 2'b11, 32'h20, 64'h1122_3344_5566_7788, 0);
        req(1'b1, 1'b0, 2'b10, 32'h24, 64'd0, 0);
        check("t4_hi_word", DATA_OUT, 64'h1122_3344);
        req(1'b1, 1'b0, 2'b10, 32'h20, 64'd0, 0);
        check("t4_lo_word", DATA_OUT, 64'h5566_7788);

        req(1'b1, 1'b1, 2'b01, 32'h11, 64'd0, 0);
        check("t5_mis_dout", DATA_OUT, 64'h5566_7788);
        req(1'b0, 1'b0, 2'b10, 32'h1FE, 64'hCAFE_F00D, 0);
        req(1'b1, 1'b0, 2'b01, 32'h1FE, 64'd0, 0);
        req(1'b0, 1'b0, 2'b00, 32'h200, 64'hAA, 0);
        req(1'b1, 1'b0, 2'b00, 32'h0, 64'd0, 0);
        check("t5_wrap", DATA_OUT, 64'hAA);

        req(1'b1, 1'b0, 2'b10, 32'h10, 64'd0, 6);

        // Store aborted in WAIT: no MOC, bytes unchanged, next request normal.
        MFA = 1'b1; RW = 1'b0; SIZE = 2'b10; ADDR = 32'h10;
        DATA_IN = 64'h0BAD_0BAD;
        @(posedge Clk);
        @(negedge Clk);
        MFA = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (MOC) seen = 1'b1;
        end
        check("abort_no_moc", 64'(seen), 64'd0);
        req(1'b1, 1'b0, 2'b10, 32'h10, 64'd0, 0);

        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            req(1'($urandom), 1'($urandom), sz, a, {$urandom, $urandom}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
